// File: rtl/agen_burst.sv
// ---------------------------------------------------------------------------
// agen_burst -- burst address generator
//
// Purpose:
//   Accepts one addressing request (base, scaled index, displacement, mode),
//   computes the effective address in a single CALC cycle, then emits one
//   memory address per beat under a valid/ready handshake.
//   - The address steps up (dir=0) or down (dir=1) by esize bytes per beat.
//   - After the final beat a one-cycle strobe carries the base-register
//     writeback value for the addressing mode.
//   All arithmetic wraps modulo 2^AWID.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i/ready_o request handshake; the fields below are sampled at
//                       acceptance only
//   base_i, index_i,    address operands (AWID bits)
//   disp_i
//   scale_i             index scale selector (0..4 shift, 5/6/7 = x5/x10/x15)
//   mode_i              0 plain, 1 pre-decrement, 2 post-increment,
//                       3 writeback of the effective address
//   beats_i             beat count, 0 is treated as 1
//   dir_i               0 ascending, 1 descending
//   esize_i             element stride in bytes
//   ma_o/ma_valid_o/    beat address stream with handshake, final-beat flag
//   ma_ready_i/ma_last_o and beat number
//   ma_idx_o
//   res2_o/res2_valid_o base-register writeback value and its strobe
//   abort_i             synchronous cancel of the current burst
//   busy_o              high while a burst is in progress
// ---------------------------------------------------------------------------
module agen_burst #(
  parameter int AWID = 80,
  parameter int CNTW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [AWID-1:0] base_i,
  input  logic [AWID-1:0] index_i,
  input  logic [AWID-1:0] disp_i,
  input  logic [2:0]      scale_i,
  input  logic [1:0]      mode_i,
  input  logic [CNTW-1:0] beats_i,
  input  logic            dir_i,
  input  logic [4:0]      esize_i,
  output logic [AWID-1:0] ma_o,
  output logic            ma_valid_o,
  input  logic            ma_ready_i,
  output logic            ma_last_o,
  output logic [CNTW-1:0] ma_idx_o,
  output logic [AWID-1:0] res2_o,
  output logic            res2_valid_o,
  input  logic            abort_i,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t state_reg;

  // Request fields captured at acceptance.
  logic [AWID-1:0] base_reg;
  logic [AWID-1:0] index_reg;
  logic [AWID-1:0] disp_reg;
  logic [2:0]      scale_reg;
  logic [1:0]      mode_reg;
  logic [CNTW-1:0] beats_reg;
  logic            dir_reg;
  logic [4:0]      esize_reg;

  // Effective address, produced in CALC.
  logic [AWID-1:0] ea_reg;

  // Scaled-index and weight candidates for each scale code; the registered
  // scale selects one. The x5/x10/x15 products are constant multiplies.
  logic [AWID-1:0] sx_cand [8];
  logic [AWID-1:0] dx_cand [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_scale
      if (gi < 5) begin : g_shift
        assign sx_cand[gi] = index_reg << gi;
        assign dx_cand[gi] = AWID'(1) << gi;
      end else begin : g_mul
        localparam int unsigned MULT = (gi == 5) ? 5 : ((gi == 6) ? 10 : 15);
        assign sx_cand[gi] = index_reg * AWID'(MULT);
        assign dx_cand[gi] = AWID'(MULT);
      end
    end
  endgenerate

  logic [AWID-1:0] sx;
  logic [AWID-1:0] dx;
  logic [AWID-1:0] ea_next;
  logic [AWID-1:0] stride;
  logic [AWID-1:0] step_addr;
  logic [CNTW-1:0] idx_inc;
  logic [CNTW-1:0] last_idx;
  logic [AWID-1:0] res2_next;

  assign sx = sx_cand[scale_reg];
  assign dx = dx_cand[scale_reg];

  // Pre-decrement folds the weight into the effective address itself.
  assign ea_next = base_reg + sx + disp_reg - ((mode_reg == 2'd1) ? dx : '0);

  // Successive beats are formed incrementally from the current address, which
  // equals ea +/- n*esize modulo 2^AWID.
  assign stride    = AWID'(esize_reg);
  assign step_addr = dir_reg ? (ma_o - stride) : (ma_o + stride);
  assign idx_inc   = ma_idx_o + 1'b1;
  assign last_idx  = beats_reg - 1'b1;

  always_comb begin
    res2_next = base_reg;
    case (mode_reg)
      2'd0:    res2_next = base_reg;
      2'd1:    res2_next = base_reg - dx;
      2'd2:    res2_next = base_reg + dx;
      default: res2_next = ea_reg;
    endcase
  end

  assign req_ready_o = (state_reg == IDLE) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      index_reg    <= '0;
      disp_reg     <= '0;
      scale_reg    <= '0;
      mode_reg     <= '0;
      beats_reg    <= '0;
      dir_reg      <= 1'b0;
      esize_reg    <= '0;
      ea_reg       <= '0;
      ma_o         <= '0;
      ma_valid_o   <= 1'b0;
      ma_last_o    <= 1'b0;
      ma_idx_o     <= '0;
      res2_o       <= '0;
      res2_valid_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      // The writeback strobe is a single-cycle pulse.
      res2_valid_o <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            base_reg  <= base_i;
            index_reg <= index_i;
            disp_reg  <= disp_i;
            scale_reg <= scale_i;
            mode_reg  <= mode_i;
            beats_reg <= (beats_i == '0) ? CNTW'(1) : beats_i;
            dir_reg   <= dir_i;
            esize_reg <= esize_i;
            state_reg <= CALC;
            busy_o    <= 1'b1;
          end
        end

        CALC: begin
          if (abort_i) begin
            state_reg <= IDLE;
            busy_o    <= 1'b0;
          end else begin
            ea_reg    <= ea_next;
            state_reg <= EMIT;
          end
        end

        EMIT: begin
          if (abort_i) begin
            // A handshake coincident with abort still counts as transferred;
            // the writeback is simply never issued.
            state_reg  <= IDLE;
            ma_valid_o <= 1'b0;
            busy_o     <= 1'b0;
          end else if (!ma_valid_o) begin
            // First EMIT cycle: present beat 0 from the registered address.
            ma_o       <= ea_reg;
            ma_idx_o   <= '0;
            ma_last_o  <= (beats_reg == CNTW'(1));
            ma_valid_o <= 1'b1;
          end else if (ma_ready_i) begin
            if (ma_last_o) begin
              state_reg    <= IDLE;
              ma_valid_o   <= 1'b0;
              busy_o       <= 1'b0;
              res2_o       <= res2_next;
              res2_valid_o <= 1'b1;
            end else begin
              ma_o      <= step_addr;
              ma_idx_o  <= idx_inc;
              ma_last_o <= (idx_inc == last_idx);
            end
          end
        end

        default: begin
          state_reg  <= IDLE;
          ma_valid_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule
